snes_multi_encoder: RTL

SNES_MULTI_ENCODER -- requirements
Module: snes_multi_encoder

---
 rtl/snes_multi_encoder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/snes_multi_encoder.sv
// Multi-source SNES controller encoder.
// Merges button words from several controller sources (fixed select, OR-merge
// or auto-priority), masks sources that have gone stale, and serialises the
// merged word onto the console's latch/clock protocol, LSB first, active-low.
//
// Ports:
//   i_clock, i_reset        system clock, async active-high reset
//   i_src_data, i_src_valid per-source button words and refresh strobes
//   i_sel, i_mode           fixed-mode source index, merge mode
//   i_snes_latch, i_snes_clk console pins (asynchronous to i_clock)
//   o_snes_out              serial data to console, 0 = pressed
//   o_active_src            source index captured at the last load
//   o_frame_count           number of latch loads, wrapping
module snes_multi_encoder #(
  parameter int unsigned NUM_SRC      = 3,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STALE_CYCLES = 65535
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [NUM_SRC*DATA_W-1:0]    i_src_data,
  input  logic [NUM_SRC-1:0]           i_src_valid,
  input  logic [$clog2(NUM_SRC)-1:0]   i_sel,
  input  logic [1:0]                   i_mode,
  input  logic                         i_snes_latch,
  input  logic                         i_snes_clk,
  output logic                         o_snes_out,
  output logic [$clog2(NUM_SRC)-1:0]   o_active_src,
  output logic [7:0]                   o_frame_count
);

  localparam int unsigned SEL_W = $clog2(NUM_SRC);
  localparam int unsigned CNT_W = $clog2(STALE_CYCLES + 1);

  logic [DATA_W-1:0]  r_hold      [NUM_SRC];
  logic [CNT_W-1:0]   r_stale_cnt [NUM_SRC];
  logic [NUM_SRC-1:0] w_fresh;
  logic [DATA_W-1:0]  w_merged;
  logic [SEL_W-1:0]   w_active;
  logic               w_found;
  logic [DATA_W-1:0]  r_shift;
  logic [DATA_W-1:0]  w_shift_next;
  logic [SEL_W-1:0]   r_active_src;
  logic [7:0]         r_frame_count;
  logic               r_snes_out;
  logic [1:0]         r_latch_sync;
  logic [1:0]         r_clk_sync;
  logic               r_latch_prev;
  logic               r_clk_prev;
  logic               w_latch_lvl;
  logic               w_latch_rise;
  logic               w_clk_rise;

  // Holding registers and staleness counters per source
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        r_hold[i]      <= '0;
        r_stale_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (i_src_valid[i]) begin
          r_hold[i]      <= i_src_data[i*DATA_W +: DATA_W];
          r_stale_cnt[i] <= CNT_W'(STALE_CYCLES);
        end else if (r_stale_cnt[i] != '0) begin
          r_stale_cnt[i] <= r_stale_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // A source with an expired counter contributes nothing
  always_comb begin
    w_fresh = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_fresh[i] = (r_stale_cnt[i] != '0);
    end
  end

  // Merge selection
  always_comb begin
    w_merged = '0;
    w_active = '0;
    w_found  = 1'b0;
    case (i_mode)
      2'b01: begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if (w_fresh[i]) w_merged = w_merged | r_hold[i];
        end
      end
      2'b10: begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if (!w_found && w_fresh[i] && (r_hold[i] != '0)) begin
            w_merged = r_hold[i];
            w_active = SEL_W'(i);
            w_found  = 1'b1;
          end
        end
      end
      default: begin
        w_active = (32'(i_sel) >= NUM_SRC) ? SEL_W'(NUM_SRC - 1) : i_sel;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
          if ((i_sel == SEL_W'(i)) && w_fresh[i]) w_merged = r_hold[i];
        end
      end
    endcase
  end

  // Two-flop synchronisers plus edge history for the console pins
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_latch_sync <= '0;
      r_clk_sync   <= '0;
      r_latch_prev <= 1'b0;
      r_clk_prev   <= 1'b0;
    end else begin
      r_latch_sync <= {r_latch_sync[0], i_snes_latch};
      r_clk_sync   <= {r_clk_sync[0], i_snes_clk};
      r_latch_prev <= r_latch_sync[1];
      r_clk_prev   <= r_clk_sync[1];
    end
  end

  assign w_latch_lvl  = r_latch_sync[1];
  assign w_latch_rise = r_latch_sync[1] & ~r_latch_prev;
  assign w_clk_rise   = r_clk_sync[1] & ~r_clk_prev;

  // Latch level keeps reloading (parallel mode) and overrides any shift
  always_comb begin
    w_shift_next = r_shift;
    if (w_latch_lvl) begin
      w_shift_next = w_merged;
    end else if (w_clk_rise) begin
      w_shift_next = {1'b0, r_shift[DATA_W-1:1]};
    end
  end

  // Shift register, registered pin output and frame bookkeeping
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_shift       <= '0;
      r_snes_out    <= 1'b1;
      r_active_src  <= '0;
      r_frame_count <= '0;
    end else begin
      r_shift    <= w_shift_next;
      r_snes_out <= ~w_shift_next[0];
      if (w_latch_rise) begin
        r_active_src  <= w_active;
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign o_snes_out    = r_snes_out;
  assign o_active_src  = r_active_src;
  assign o_frame_count = r_frame_count;

endmodule
